// File: rtl/matmul_pkg.sv
// Shared types and helpers for the parametrised matrix-multiply engine:
// FSM state encoding, host port select codes and row-major addressing.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // Row-major element address; every matrix uses the same MAX_DIM stride.
  function automatic int unsigned elem_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned max_dim);
    return row * max_dim + col;
  endfunction

endpackage

// File: rtl/param_matmul_engine_mac_unit.sv
// Stage-2 multiply-accumulate: signed/unsigned product extended to the
// accumulator width, with either a fresh load or a running accumulate.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  signed_mode,
  input  logic                  clear_load,
  input  logic [ACC_WIDTH-1:0]  load_val,
  input  logic                  en,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int XW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

  logic [XW-1:0]        a_ext;
  logic [XW-1:0]        b_ext;
  logic [XW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_acc;

  // Extending both operands to the result width first makes the low bits of
  // a plain multiply correct for both signed and unsigned operands.
  always_comb begin
    a_ext    = {{(XW-DATA_WIDTH){signed_mode & a[DATA_WIDTH-1]}}, a};
    b_ext    = {{(XW-DATA_WIDTH){signed_mode & b[DATA_WIDTH-1]}}, b};
    prod     = a_ext * b_ext;
    prod_acc = prod[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clear_load ? load_val : acc) + prod_acc;
    end
  end

endmodule

// File: rtl/param_matmul_engine.sv
// Runtime-sized C = A*B (optionally C += A*B) engine: one MAC per cycle,
// k innermost, 2-stage pipeline, host load/readback port while idle.
module param_matmul_engine
  import matmul_pkg::*;
#(
  parameter int MAX_DIM    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int DIM_W      = $clog2(MAX_DIM+1),
  parameter int ADDR_W     = $clog2(MAX_DIM*MAX_DIM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIM_W-1:0]     cfg_m,
  input  logic [DIM_W-1:0]     cfg_n,
  input  logic [DIM_W-1:0]     cfg_k,
  input  logic                 cfg_signed,
  input  logic                 cfg_accum,
  input  logic                 host_we,
  input  logic [1:0]           host_sel,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [ACC_WIDTH-1:0] host_wdata,
  output logic [ACC_WIDTH-1:0] host_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // state   | meaning
  // S_IDLE  | host port active, waiting for start
  // S_RUN   | issuing one (i,j,k) per cycle
  // S_DRAIN | two cycles to flush the MAC pipeline and final C write
  // S_DONE  | one-cycle done pulse

  localparam int               DEPTH = MAX_DIM * MAX_DIM;
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [DEPTH];
  logic [ACC_WIDTH-1:0]  mem_c [DEPTH];

  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [DIM_W-1:0] i_q, j_q, kk_q;
  logic             sgn_q, accum_q;
  logic             drain_cnt;

  logic             cfg_bad;
  logic             accept;
  logic             last_i, last_j, last_k, last_issue;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;

  logic                  s1_valid, s1_first, s1_last;
  logic [ADDR_W-1:0]     s1_tag;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic [ACC_WIDTH-1:0]  s1_c;
  logic                  s2_wr;
  logic [ADDR_W-1:0]     s2_tag;
  logic [ACC_WIDTH-1:0]  mac_acc;
  logic [ACC_WIDTH-1:0]  mac_load;

  always_comb begin
    cfg_bad = (cfg_m == '0) || (cfg_m > MAX_D) ||
              (cfg_n == '0) || (cfg_n > MAX_D) ||
              (cfg_k == '0) || (cfg_k > MAX_D);
    accept     = (state == S_IDLE) && start;
    last_i     = (i_q == m_q - ONE);
    last_j     = (j_q == n_q - ONE);
    last_k     = (kk_q == k_q - ONE);
    last_issue = (state == S_RUN) && last_i && last_j && last_k;
    a_addr     = ADDR_W'(elem_addr(32'(i_q), 32'(kk_q), 32'(MAX_DIM)));
    b_addr     = ADDR_W'(elem_addr(32'(kk_q), 32'(j_q), 32'(MAX_DIM)));
    c_addr     = ADDR_W'(elem_addr(32'(i_q), 32'(j_q), 32'(MAX_DIM)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = cfg_bad ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 1'b0) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      sgn_q     <= 1'b0;
      accum_q   <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      kk_q      <= '0;
      err       <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      if (accept) begin
        m_q     <= cfg_m;
        n_q     <= cfg_n;
        k_q     <= cfg_k;
        sgn_q   <= cfg_signed;
        accum_q <= cfg_accum;
        i_q     <= '0;
        j_q     <= '0;
        kk_q    <= '0;
        err     <= cfg_bad;
      end else if (state == S_RUN) begin
        if (last_k) begin
          kk_q <= '0;
          if (last_j) begin
            j_q <= '0;
            i_q <= i_q + ONE;
          end else begin
            j_q <= j_q + ONE;
          end
        end else begin
          kk_q <= kk_q + ONE;
        end
      end
      if (last_issue)             drain_cnt <= 1'b1;
      else if (state == S_DRAIN)  drain_cnt <= 1'b0;
    end
  end

  // Stage 1: operand fetch with (i,j) tag; C is only consumed at k==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s2_wr    <= 1'b0;
      s2_tag   <= '0;
    end else begin
      s1_valid <= (state == S_RUN);
      s1_first <= (kk_q == '0);
      s1_last  <= last_k;
      s1_tag   <= c_addr;
      s1_a     <= mem_a[a_addr];
      s1_b     <= mem_b[b_addr];
      s1_c     <= mem_c[c_addr];
      s2_wr    <= s1_valid & s1_last;
      s2_tag   <= s1_tag;
    end
  end

  assign mac_load = accum_q ? s1_c : '0;

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (s1_a),
    .b           (s1_b),
    .signed_mode (sgn_q),
    .clear_load  (s1_first),
    .load_val    (mac_load),
    .en          (s1_valid),
    .acc         (mac_acc)
  );

  // Host writes only happen in S_IDLE and engine writes only while busy,
  // so the two mem_c write sources never collide.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && host_we) begin
      case (host_sel)
        SEL_A:   mem_a[host_addr] <= host_wdata[DATA_WIDTH-1:0];
        SEL_B:   mem_b[host_addr] <= host_wdata[DATA_WIDTH-1:0];
        SEL_C:   mem_c[host_addr] <= host_wdata;
        default: ;
      endcase
    end
    if (s2_wr) mem_c[s2_tag] <= mac_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 host_rdata <= '0;
    else if (state == S_IDLE)   host_rdata <= mem_c[host_addr];
  end

endmodule

// File: tb/tb_param_matmul_engine.sv
// Scoreboard bench for param_matmul_engine: a golden matrix model fills an
// expected-C queue at each start, drained by host readback after done.
module tb_param_matmul_engine;

  localparam int MAX_DIM = 16;
  localparam int DIM_W   = 5;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = MAX_DIM * MAX_DIM;

  logic              clk, rst_n, start;
  logic [DIM_W-1:0]  cfg_m, cfg_n, cfg_k;
  logic              cfg_signed, cfg_accum;
  logic              host_we;
  logic [1:0]        host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              busy, done, err;
  logic [15:0]       host_rdata16;
  logic              busy16, done16, err16;

  param_matmul_engine #(.MAX_DIM(MAX_DIM), .DATA_WIDTH(8), .ACC_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .cfg_signed(cfg_signed), .cfg_accum(cfg_accum),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .busy(busy), .done(done), .err(err)
  );

  param_matmul_engine #(.MAX_DIM(MAX_DIM), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .cfg_signed(cfg_signed), .cfg_accum(cfg_accum),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata[15:0]), .host_rdata(host_rdata16),
    .busy(busy16), .done(done16), .err(err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       val;
    bit                w16;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ma [DEPTH];
  logic [7:0]  mb [DEPTH];
  logic [31:0] mc [DEPTH];
  logic [15:0] mc16 [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [1:0] sel, input int addr, input logic [31:0] data);
    @(negedge clk);
    host_we    = 1'b1;
    host_sel   = sel;
    host_addr  = ADDR_W'(addr);
    host_wdata = data;
    case (sel)
      2'd0: ma[addr] = data[7:0];
      2'd1: mb[addr] = data[7:0];
      2'd2: begin mc[addr] = data; mc16[addr] = data[15:0]; end
      default: ;
    endcase
  endtask

  task automatic host_idle();
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int addr, input logic [31:0] exp);
    @(negedge clk);
    host_addr = ADDR_W'(addr);
    @(negedge clk);
    check_eq(tag, host_rdata, exp);
  endtask

  task automatic golden(input int m, input int n, input int k, input bit sgn, input bit acc);
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        logic [31:0] s32;
        logic [15:0] s16;
        s32 = acc ? mc[i*MAX_DIM+j] : 32'd0;
        s16 = acc ? mc16[i*MAX_DIM+j] : 16'd0;
        for (int kk = 0; kk < k; kk++) begin
          int          av, bv;
          logic [31:0] p;
          av  = sgn ? int'($signed(ma[i*MAX_DIM+kk])) : int'(ma[i*MAX_DIM+kk]);
          bv  = sgn ? int'($signed(mb[kk*MAX_DIM+j])) : int'(mb[kk*MAX_DIM+j]);
          p   = av * bv;
          s32 = s32 + p;
          s16 = s16 + p[15:0];
        end
        mc[i*MAX_DIM+j]   = s32;
        mc16[i*MAX_DIM+j] = s16;
      end
    end
  endtask

  task automatic push_all(input bit w16);
    for (int a = 0; a < DEPTH; a++)
      sb.push_back('{addr: ADDR_W'(a), val: (w16 ? {16'd0, mc16[a]} : mc[a]), w16: w16});
  endtask

  task automatic drain_sb(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      host_addr = e.addr;
      @(negedge clk);
      check_eq($sformatf("%s_c%0d%s", tag, e.addr, e.w16 ? "_w16" : ""),
               e.w16 ? {16'd0, host_rdata16} : host_rdata, e.val);
    end
  endtask

  // Launch a run, push expected C, count edges to done, then read back C.
  task automatic run(input string tag, input int m, input int n, input int k,
                     input bit sgn, input bit acc, input int exp_edges,
                     input bit exp_err, input bit disturb, input bit sim_wr,
                     input bit also16);
    int edges;
    int busy_low;
    bit bad;
    bad = (m == 0) || (m > MAX_DIM) || (n == 0) || (n > MAX_DIM) ||
          (k == 0) || (k > MAX_DIM);
    @(negedge clk);
    cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k);
    cfg_signed = sgn; cfg_accum = acc;
    start = 1'b1;
    if (sim_wr) begin
      host_we = 1'b1; host_sel = 2'd0; host_addr = '0; host_wdata = 32'd5;
      ma[0] = 8'd5;
    end
    if (!bad) golden(m, n, k, sgn, acc);
    push_all(1'b0);
    if (also16) push_all(1'b1);
    @(negedge clk);
    start = 1'b0;
    host_we = 1'b0;
    edges = 1;
    busy_low = 0;
    host_sel = 2'd0; host_addr = '0; host_wdata = 32'h55;
    while (done !== 1'b1 && edges < exp_edges + 20) begin
      if (busy !== 1'b1) busy_low++;
      start   = disturb && (edges == 3);
      host_we = disturb && (edges == 3);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    host_we = 1'b0;
    check_eq({tag, "_done_edge"}, edges, exp_edges);
    check_eq({tag, "_busy_low_cycles"}, busy_low, 0);
    check_eq({tag, "_busy_at_done"}, busy, 1'b1);
    check_eq({tag, "_done16"}, done16, 1'b1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 1'b0);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
    check_eq({tag, "_err"}, err, exp_err);
    drain_sb(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; host_we = 1'b0; host_sel = 2'd0;
    host_addr = '0; host_wdata = '0; cfg_m = '0; cfg_n = '0; cfg_k = '0;
    cfg_signed = 1'b0; cfg_accum = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_rdata", host_rdata, 32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) host_wr(2'd2, a, 32'hA5A5_0000 + 32'(a));
    for (int a = 0; a < DEPTH; a++) begin
      host_wr(2'd0, a, 32'd0);
      host_wr(2'd1, a, 32'd0);
    end
    host_wr(2'd0, 0, 1);  host_wr(2'd0, 1, 2);
    host_wr(2'd0, 16, 3); host_wr(2'd0, 17, 4);
    host_wr(2'd1, 0, 1);  host_wr(2'd1, 17, 1);
    host_wr(2'd3, 5, 32'hDEAD);
    host_idle();

    run("ident", 2, 2, 2, 0, 0, 11, 0, 0, 0, 0);
    rd_check("ident_c01", 1, 32'd2);
    rd_check("ident_c11", 17, 32'd4);
    run("acc0", 2, 2, 2, 0, 0, 11, 0, 0, 0, 0);
    run("acc1", 2, 2, 2, 0, 1, 11, 0, 0, 0, 0);
    rd_check("acc1_c11", 17, 32'd8);
    run("acc_restore", 2, 2, 2, 0, 0, 11, 0, 0, 0, 0);
    run("wr_start", 2, 2, 2, 0, 0, 11, 0, 0, 1, 0);
    rd_check("wr_start_c00", 0, 32'd5);

    for (int kk = 0; kk < 4; kk++) begin
      host_wr(2'd0, 0*MAX_DIM+kk, 32'h80);
      host_wr(2'd1, kk*MAX_DIM+0, 32'h80);
    end
    host_wr(2'd0, 16, 32'hFF); host_wr(2'd0, 17, 2);
    host_wr(2'd0, 18, 32'hFF); host_wr(2'd0, 19, 3);
    host_wr(2'd0, 32, 127);    host_wr(2'd0, 33, 32'h80);
    host_wr(2'd0, 34, 32'hFF); host_wr(2'd0, 35, 0);
    host_wr(2'd1, 1, 32'hFF);  host_wr(2'd1, 17, 1);
    host_wr(2'd1, 33, 32'hFF); host_wr(2'd1, 49, 5);
    host_idle();
    run("signed", 3, 2, 4, 1, 0, 27, 0, 0, 0, 0);
    rd_check("signed_c00", 0, 32'd65536);

    run("err_k0", 2, 2, 0, 0, 0, 1, 1, 0, 0, 0);
    check_eq("err_sticky", err, 1'b1);
    run("err_m17", 17, 2, 2, 0, 0, 1, 1, 0, 0, 0);
    run("err_clear", 2, 2, 2, 0, 0, 11, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        host_wr(2'd0, i*MAX_DIM+j, 32'($urandom_range(0, 255)));
        host_wr(2'd1, i*MAX_DIM+j, 32'($urandom_range(0, 255)));
      end
    host_idle();
    run("disturb", 3, 3, 3, 0, 0, 30, 0, 1, 0, 0);

    @(negedge clk);
    cfg_m = 5'd4; cfg_n = 5'd4; cfg_k = 5'd4; cfg_signed = 1'b1; cfg_accum = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_rdata", host_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 4, 4, 4, 1, 0, 67, 0, 0, 0, 0);

    for (int a = 0; a < DEPTH; a++) begin
      host_wr(2'd0, a, 32'hFF);
      host_wr(2'd1, a, 32'hFF);
    end
    host_idle();
    run("cube", 16, 16, 16, 0, 0, 16*16*16 + 3, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
